cci_mpf_prim_lru_ref_queue: RTL and testbench

Reference-coalescing queue that sits directly upstream of one update port of the pseudo-LRU replacement table. It accepts way-hit events from the cache tag pipeline one per cycle and never back-pressures. It merges repeated hits to the same set and spaces issues so that no set is re-referenced while an earlier read/modify/write to that set is still in flight downstream. This turns the "best effort" LRU port into one that loses references only on queue overflow, and that loss is counted.

---
 rtl/cci_mpf_prim_lru_ref_pkg.sv | 9 +
 rtl/cci_mpf_prim_lru_ref_hist.sv | 47 ++++
 rtl/cci_mpf_prim_lru_ref_queue.sv | 167 ++++++++++++++++
 tb/tb_cci_mpf_prim_lru_ref_queue.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cci_mpf_prim_lru_ref_pkg.sv
// Shared types for the LRU reference-coalescing queue.
// The drop counter type is used only when CCI_MPF_LRU_REF_STATS_EN is defined.
package cci_mpf_prim_lru_ref_pkg;

  localparam int LRU_REF_STATS_W = 32;

  typedef logic [LRU_REF_STATS_W-1:0] t_lru_ref_drop_cnt;

endpackage

// File: rtl/cci_mpf_prim_lru_ref_hist.sv
// Recently issued set indices. Any index found here still has an LRU
// read/modify/write in flight and must not be issued again yet.
module cci_mpf_prim_lru_ref_hist
  import cci_mpf_prim_lru_ref_pkg::*;
#(
  parameter int IDX_W   = 10,
  parameter int N_QUERY = 4,
  parameter int DEPTH   = 3
)(
  input  logic                            clk,
  input  logic                            reset,
  input  logic [IDX_W-1:0]                i_iss_idx,
  input  logic                            i_iss_en,
  input  logic [N_QUERY-1:0][IDX_W-1:0]   i_qry_idx,
  output logic [N_QUERY-1:0]              o_match
);

  logic [DEPTH-1:0]            r_valid;
  logic [DEPTH-1:0][IDX_W-1:0] r_idx;

  // Shifts every cycle so an empty issue slot also ages older entries out
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
      r_idx   <= '0;
    end else begin
      r_valid[0] <= i_iss_en;
      r_idx[0]   <= i_iss_idx;
      for (int k = 1; k < DEPTH; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_idx[k]   <= r_idx[k-1];
      end
    end
  end

  always_comb begin
    o_match = '0;
    for (int q = 0; q < N_QUERY; q++) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (r_valid[k] && (r_idx[k] == i_qry_idx[q])) begin
          o_match[q] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cci_mpf_prim_lru_ref_queue.sv
// Coalescing, RMW-spacing queue feeding one pseudo-LRU update port.
// Define CCI_MPF_LRU_REF_STATS_EN to add the saturating nDropped counter.
module cci_mpf_prim_lru_ref_queue
  import cci_mpf_prim_lru_ref_pkg::*;
#(
  parameter int N_WAYS     = 4,
  parameter int N_ENTRIES  = 1024,
  parameter int N_QUEUE    = 4,
  parameter int RMW_WINDOW = 3
)(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          lruRdy,
  input  logic [$clog2(N_ENTRIES)-1:0]  hitIdx,
  input  logic [$clog2(N_WAYS)-1:0]     hitWay,
  input  logic                          hitEn,
  output logic [$clog2(N_ENTRIES)-1:0]  refIdx,
  output logic [N_WAYS-1:0]             refWayVec,
  output logic                          refEn,
  output logic                          qFull
`ifdef CCI_MPF_LRU_REF_STATS_EN
  ,
  output t_lru_ref_drop_cnt             nDropped
`endif
);

  localparam int IDX_W  = $clog2(N_ENTRIES);
  localparam int SLOT_W = $clog2(N_QUEUE);

  typedef logic [IDX_W-1:0]  t_idx;
  typedef logic [N_WAYS-1:0] t_way_vec;

  logic     [N_QUEUE-1:0] r_valid;
  t_idx     [N_QUEUE-1:0] r_idx;
  t_way_vec [N_QUEUE-1:0] r_vec;

  logic     [N_QUEUE-1:0] w_blocked;
  logic                   w_iss_en;
  logic     [SLOT_W-1:0]  w_iss_sel;
  t_idx                   w_iss_idx;

  logic     [N_QUEUE-1:0] w_sh_valid;
  t_idx     [N_QUEUE-1:0] w_sh_idx;
  t_way_vec [N_QUEUE-1:0] w_sh_vec;
  logic     [N_QUEUE-1:0] w_c_valid;
  t_idx     [N_QUEUE-1:0] w_c_idx;
  t_way_vec [N_QUEUE-1:0] w_c_vec;
  logic     [N_QUEUE-1:0] w_n_valid;
  t_idx     [N_QUEUE-1:0] w_n_idx;
  t_way_vec [N_QUEUE-1:0] w_n_vec;

  t_way_vec               w_hit_vec;
  logic                   w_placed;
  logic                   w_drop;

  cci_mpf_prim_lru_ref_hist #(
    .IDX_W   (IDX_W),
    .N_QUERY (N_QUEUE),
    .DEPTH   (RMW_WINDOW)
  ) u_hist (
    .clk       (clk),
    .reset     (reset),
    .i_iss_idx (w_iss_idx),
    .i_iss_en  (w_iss_en),
    .i_qry_idx (r_idx),
    .o_match   (w_blocked)
  );

  // Descending scan so the oldest eligible slot wins
  always_comb begin
    w_iss_en  = 1'b0;
    w_iss_sel = '0;
    for (int i = N_QUEUE - 1; i >= 0; i--) begin
      if (lruRdy && r_valid[i] && !w_blocked[i]) begin
        w_iss_en  = 1'b1;
        w_iss_sel = SLOT_W'(i);
      end
    end
  end

  assign w_iss_idx = r_idx[w_iss_sel];

  assign w_sh_valid = {1'b0, r_valid[N_QUEUE-1:1]};
  assign w_sh_idx   = {t_idx'(0), r_idx[N_QUEUE-1:1]};
  assign w_sh_vec   = {t_way_vec'(0), r_vec[N_QUEUE-1:1]};

  always_comb begin
    w_c_valid = r_valid;
    w_c_idx   = r_idx;
    w_c_vec   = r_vec;
    for (int i = 0; i < N_QUEUE; i++) begin
      if (w_iss_en && (i >= int'(w_iss_sel))) begin
        w_c_valid[i] = w_sh_valid[i];
        w_c_idx[i]   = w_sh_idx[i];
        w_c_vec[i]   = w_sh_vec[i];
      end
    end
  end

  // Hits merge into the post-removal queue, so a hit to the index being
  // issued this cycle lands in a fresh tail slot instead of vanishing.
  always_comb begin
    w_hit_vec = t_way_vec'(1) << hitWay;
    w_n_valid = w_c_valid;
    w_n_idx   = w_c_idx;
    w_n_vec   = w_c_vec;
    w_placed  = 1'b0;
    w_drop    = 1'b0;
    if (hitEn) begin
      for (int i = 0; i < N_QUEUE; i++) begin
        if (!w_placed && w_c_valid[i] && (w_c_idx[i] == hitIdx)) begin
          w_n_vec[i] = w_c_vec[i] | w_hit_vec;
          w_placed   = 1'b1;
        end
      end
      for (int i = 0; i < N_QUEUE; i++) begin
        if (!w_placed && !w_c_valid[i]) begin
          w_n_valid[i] = 1'b1;
          w_n_idx[i]   = hitIdx;
          w_n_vec[i]   = w_hit_vec;
          w_placed     = 1'b1;
        end
      end
      w_drop = !w_placed;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid   <= '0;
      r_idx     <= '0;
      r_vec     <= '0;
      refEn     <= 1'b0;
      refIdx    <= '0;
      refWayVec <= '0;
      qFull     <= 1'b0;
    end else begin
      r_valid <= w_n_valid;
      r_idx   <= w_n_idx;
      r_vec   <= w_n_vec;
      refEn   <= w_iss_en;
      if (w_iss_en) begin
        refIdx    <= w_iss_idx;
        refWayVec <= r_vec[w_iss_sel];
      end
      qFull <= &w_n_valid;
    end
  end

`ifdef CCI_MPF_LRU_REF_STATS_EN
  t_lru_ref_drop_cnt r_dropped;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dropped <= '0;
    end else if (w_drop && (r_dropped != '1)) begin
      r_dropped <= r_dropped + 1'b1;
    end
  end

  assign nDropped = r_dropped;
`else
  logic w_drop_unused;
  assign w_drop_unused = w_drop;
`endif

endmodule

// File: tb/tb_cci_mpf_prim_lru_ref_queue.sv
// Directed bench for the LRU reference queue: latency, coalescing, RMW spacing,
// overflow, full-plus-issue acceptance and asynchronous reset.
module tb_cci_mpf_prim_lru_ref_queue;
  import cci_mpf_prim_lru_ref_pkg::*;

  localparam int IDX_W = 10;
  localparam int WAY_W = 2;

  logic             clk;
  logic             reset;
  logic             lruRdy;
  logic [IDX_W-1:0] hitIdx;
  logic [WAY_W-1:0] hitWay;
  logic             hitEn;
  logic [IDX_W-1:0] refIdx;
  logic [3:0]       refWayVec;
  logic             refEn;
  logic             qFull;
`ifdef CCI_MPF_LRU_REF_STATS_EN
  t_lru_ref_drop_cnt nDropped;
`endif

  int n_asserts = 0;
  int n_fail    = 0;

  cci_mpf_prim_lru_ref_queue dut (
    .clk       (clk),
    .reset     (reset),
    .lruRdy    (lruRdy),
    .hitIdx    (hitIdx),
    .hitWay    (hitWay),
    .hitEn     (hitEn),
    .refIdx    (refIdx),
    .refWayVec (refWayVec),
    .refEn     (refEn),
    .qFull     (qFull)
`ifdef CCI_MPF_LRU_REF_STATS_EN
    ,
    .nDropped  (nDropped)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic drive_hit(input int idx, input int way);
    hitEn  = 1'b1;
    hitIdx = IDX_W'(idx);
    hitWay = WAY_W'(way);
  endtask

  task automatic chk_issue(input string tag, input int idx, input int vec);
    chk({tag, "_en"},  64'(refEn), 64'(1));
    chk({tag, "_idx"}, 64'(refIdx), 64'(idx));
    chk({tag, "_vec"}, 64'(refWayVec), 64'(vec));
  endtask

  task automatic chk_drops(input string tag, input int exp);
`ifdef CCI_MPF_LRU_REF_STATS_EN
    chk(tag, 64'(nDropped), 64'(exp));
`else
    if (exp < 0) $display("%s: negative drop count", tag);
`endif
  endtask

  int exp_q[4];

  initial begin
    reset  = 1'b1;
    lruRdy = 1'b1;
    hitEn  = 1'b0;
    hitIdx = '0;
    hitWay = '0;
    repeat (3) step();
    chk("rst_refEn", 64'(refEn), 64'(0));
    chk("rst_refIdx", 64'(refIdx), 64'(0));
    chk("rst_refWayVec", 64'(refWayVec), 64'(0));
    chk("rst_qFull", 64'(qFull), 64'(0));
    chk_drops("rst_nDropped", 0);
    reset = 1'b0;
    repeat (2) step();

    // Single hit: two-edge latency, one pulse, outputs hold afterwards
    drive_hit(5, 2);
    step();
    hitEn = 1'b0;
    chk("t1_not_yet", 64'(refEn), 64'(0));
    step();
    chk_issue("t1_issue", 5, 4'b0100);
    step();
    chk("t1_one_pulse", 64'(refEn), 64'(0));
    chk("t1_idx_hold", 64'(refIdx), 64'(5));
    chk("t1_vec_hold", 64'(refWayVec), 64'(4'b0100));
    repeat (4) step();

    // Hit to the index being issued becomes a new slot and waits out the window
    drive_hit(7, 0);
    step();
    chk("t2_not_yet", 64'(refEn), 64'(0));
    drive_hit(7, 3);
    step();
    hitEn = 1'b0;
    chk_issue("t2_first", 7, 4'b0001);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t2_window_blocked", 64'(refEn), 64'(0));
    end
    step();
    chk_issue("t2_second", 7, 4'b1000);
    step();
    chk("t2_done", 64'(refEn), 64'(0));
    repeat (4) step();

    // Coalescing while the LRU is not ready
    lruRdy = 1'b0;
    drive_hit(1, 0); step();
    drive_hit(2, 1); step();
    drive_hit(1, 2); step();
    drive_hit(3, 3); step();
    hitEn = 1'b0;
    chk("t3_qFull", 64'(qFull), 64'(0));
    chk("t3_no_issue_not_rdy", 64'(refEn), 64'(0));
    lruRdy = 1'b1;
    step();
    chk_issue("t3_i1", 1, 4'b0101);
    step();
    chk_issue("t3_i2", 2, 4'b0010);
    step();
    chk_issue("t3_i3", 3, 4'b1000);
    step();
    chk("t3_done", 64'(refEn), 64'(0));
    chk("t3_empty", 64'(qFull), 64'(0));
    repeat (4) step();

    // Overflow: six distinct hits into four slots
    lruRdy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive_hit(10 + i, 1);
      step();
      if (i == 2) chk("t4_qFull_3", 64'(qFull), 64'(0));
      if (i == 3) chk("t4_qFull_4", 64'(qFull), 64'(1));
    end
    chk_drops("t4_nDropped", 2);
    chk("t4_no_issue", 64'(refEn), 64'(0));

    // Full queue, issue and new distinct hit on the same edge
    lruRdy = 1'b1;
    drive_hit(20, 0);
    step();
    hitEn = 1'b0;
    chk_issue("t5_i10", 10, 4'b0010);
    chk("t5_qFull_kept", 64'(qFull), 64'(1));
    chk_drops("t5_nDropped_same", 2);
    exp_q[0] = 11;
    exp_q[1] = 12;
    exp_q[2] = 13;
    exp_q[3] = 20;
    for (int k = 0; k < 4; k++) begin
      step();
      chk_issue("t5_seq", exp_q[k], (k == 3) ? 4'b0001 : 4'b0010);
      if (k == 0) chk("t5_qFull_drop", 64'(qFull), 64'(0));
    end
    step();
    chk("t5_done", 64'(refEn), 64'(0));
    repeat (4) step();

    // Asynchronous reset with references pending and refEn high
    lruRdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_hit(30 + i, 0);
      step();
    end
    hitEn  = 1'b0;
    lruRdy = 1'b1;
    step();
    chk_issue("t6_pre", 30, 4'b0001);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_async_refEn", 64'(refEn), 64'(0));
    chk("t6_async_refIdx", 64'(refIdx), 64'(0));
    chk("t6_async_vec", 64'(refWayVec), 64'(0));
    chk("t6_async_qFull", 64'(qFull), 64'(0));
    chk_drops("t6_async_nDropped", 0);
    step();
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("t6_post_quiet", 64'(refEn), 64'(0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
